ccip_mem_responder: RTL

- Synthesizable CCI-P host-memory responder; the far end of the AFU requestor's c0 read / c1 write traffic.
- Sits where the FIU would in loopback and emulation builds; the requestor plus MPF-less AFU pipeline is driven with no host.
- Backs a line-addressed 512-bit memory, returns read data and write acks carrying the request mdata, and drives almost-full flow control.

---
 rtl/ccip_mem_responder_pkg.sv | 27 ++
 rtl/ccip_mem_rsp_fifo.sv | 51 +++++
 rtl/ccip_mem_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ccip_mem_responder_pkg.sv
// Shared types and constants for the CCI-P host-memory responder.
// LFSR constants serve the CCIP_MEM_RSP_JITTER_EN response gating.
package ccip_mem_responder_pkg;

  typedef logic [511:0] t_line;
  typedef logic [15:0]  t_mdata;

  typedef struct packed {
    logic   valid;
    t_mdata mdata;
    t_line  data;
  } t_rsp;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } t_state;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/ccip_mem_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
// Pushes while full are dropped; the caller flags the error.
module ccip_mem_rsp_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 528
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             popData,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = store[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) store[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush)
        wrPtr <= (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
      if (doPop)
        rdPtr <= (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

endmodule

// File: rtl/ccip_mem_responder.sv
// CCI-P host-memory responder: line memory, c0 reads, c1 writes.
// Define CCIP_MEM_RSP_JITTER_EN for LFSR-gated response FIFOs.
module ccip_mem_responder
  import ccip_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int RD_LATENCY     = 4,
  parameter int ALMFULL_SLACK  = 8,
  parameter int RSP_FIFO_DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req_valid,
  input  logic [41:0]  rd_req_addr,
  input  logic [15:0]  rd_req_mdata,
  input  logic         wr_req_valid,
  input  logic [41:0]  wr_req_addr,
  input  logic [511:0] wr_req_data,
  input  logic [15:0]  wr_req_mdata,
  output logic         rd_rsp_valid,
  output logic [511:0] rd_rsp_data,
  output logic [15:0]  rd_rsp_mdata,
  output logic         wr_rsp_valid,
  output logic [15:0]  wr_rsp_mdata,
  output logic         c0_alm_full,
  output logic         c1_alm_full,
  output logic         init_done,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
);

  localparam int   DEPTH_LINES = 1 << ADDR_WIDTH;
  localparam logic CFG_NO_ROOM = (RSP_FIFO_DEPTH <= ALMFULL_SLACK);

  typedef logic [ADDR_WIDTH-1:0] t_idx;

  t_state    state;
  t_idx      initAddr;
  logic      run;
  logic      rdAcc;
  logic      wrAcc;
  t_line     mem [DEPTH_LINES];
  t_line     memRdData;
  logic      memWe;
  t_idx      memWa;
  t_line     memWd;
  logic [RD_LATENCY-1:0] rdVld;
  t_mdata    rdMd  [RD_LATENCY];
  t_line     rdDat [1:RD_LATENCY-1];
  t_rsp      rdOut;
  logic      wrVld;
  t_mdata    wrMd;
  logic [31:0] rdCnt;
  logic [31:0] wrCnt;
  logic      unusedAddrHi;

  assign run   = (state == RUN);
  assign rdAcc = run && rd_req_valid;
  assign wrAcc = run && wr_req_valid;
  assign unusedAddrHi = ^{rd_req_addr[41:ADDR_WIDTH],
                          wr_req_addr[41:ADDR_WIDTH]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      initAddr <= '0;
    end else if (!run) begin
      initAddr <= initAddr + 1'b1;
      if (initAddr == '1) state <= RUN;
    end
  end

  // Clearing owns the write port until RUN
  always_comb begin
    memWe = wrAcc;
    memWa = wr_req_addr[ADDR_WIDTH-1:0];
    memWd = wr_req_data;
    if (!run) begin
      memWe = 1'b1;
      memWa = initAddr;
      memWd = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[memWa] <= memWd;
    memRdData <= mem[rd_req_addr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdVld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rdMd[i] <= '0;
      for (int i = 1; i < RD_LATENCY; i++) rdDat[i] <= '0;
    end else begin
      rdVld    <= {rdVld[RD_LATENCY-2:0], rdAcc};
      rdMd[0]  <= rdAcc ? rd_req_mdata : '0;
      rdDat[1] <= rdVld[0] ? memRdData : '0;
      for (int i = 1; i < RD_LATENCY; i++) rdMd[i] <= rdMd[i-1];
      for (int i = 2; i < RD_LATENCY; i++) rdDat[i] <= rdDat[i-1];
    end
  end

  assign rdOut = {rdVld[RD_LATENCY-1],
                  rdMd[RD_LATENCY-1],
                  rdDat[RD_LATENCY-1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrVld <= 1'b0;
      wrMd  <= '0;
      rdCnt <= '0;
      wrCnt <= '0;
    end else begin
      wrVld <= wrAcc;
      wrMd  <= wrAcc ? wr_req_mdata : '0;
      rdCnt <= rdCnt + 32'(rdAcc);
      wrCnt <= wrCnt + 32'(wrAcc);
    end
  end

  assign rd_count  = rdCnt;
  assign wr_count  = wrCnt;
  assign init_done = run;

`ifdef CCIP_MEM_RSP_JITTER_EN

  localparam int CW     = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int THRESH = RSP_FIFO_DEPTH - ALMFULL_SLACK;

  logic [15:0]  lfsr;
  logic         rdPop;
  logic         wrPop;
  logic         rdFull;
  logic         wrFull;
  logic         rdEmpty;
  logic         wrEmpty;
  logic [CW-1:0] rdFill;
  logic [CW-1:0] wrFill;
  logic [527:0] rdHead;
  t_mdata       wrHead;
  logic         ovfSticky;
  logic         unusedOvf;

  assign unusedOvf = ovfSticky;
  assign rdPop = lfsr[0] && !rdEmpty;
  assign wrPop = lfsr[0] && !wrEmpty;

  ccip_mem_rsp_fifo #(.DEPTH(RSP_FIFO_DEPTH), .WIDTH(528)) uRdFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rdOut.valid),
    .pushData ({rdOut.mdata, rdOut.data}),
    .pop      (rdPop),
    .popData  (rdHead),
    .count    (rdFill),
    .full     (rdFull),
    .empty    (rdEmpty)
  );

  ccip_mem_rsp_fifo #(.DEPTH(RSP_FIFO_DEPTH), .WIDTH(16)) uWrFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wrVld),
    .pushData (wrMd),
    .pop      (wrPop),
    .popData  (wrHead),
    .count    (wrFill),
    .full     (wrFull),
    .empty    (wrEmpty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr         <= LFSR_SEED;
      rd_rsp_valid <= 1'b0;
      rd_rsp_mdata <= '0;
      rd_rsp_data  <= '0;
      wr_rsp_valid <= 1'b0;
      wr_rsp_mdata <= '0;
      ovfSticky    <= 1'b0;
    end else begin
      lfsr         <= lfsrNext(lfsr);
      rd_rsp_valid <= rdPop;
      rd_rsp_mdata <= rdPop ? rdHead[527:512] : '0;
      rd_rsp_data  <= rdPop ? rdHead[511:0] : '0;
      wr_rsp_valid <= wrPop;
      wr_rsp_mdata <= wrPop ? wrHead : '0;
      if ((rdOut.valid && rdFull) || (wrVld && wrFull))
        ovfSticky <= 1'b1;
    end
  end

  // Pipeline entries will land in the FIFO, so they count as occupancy
  assign c0_alm_full = !run || CFG_NO_ROOM ||
                       (int'(rdFill) + $countones(rdVld) >= THRESH);
  assign c1_alm_full = !run || CFG_NO_ROOM ||
                       (int'(wrFill) + int'(wrVld) >= THRESH);

`else

  assign rd_rsp_valid = rdOut.valid;
  assign rd_rsp_mdata = rdOut.mdata;
  assign rd_rsp_data  = rdOut.data;
  assign wr_rsp_valid = wrVld;
  assign wr_rsp_mdata = wrMd;
  assign c0_alm_full  = !run || CFG_NO_ROOM;
  assign c1_alm_full  = !run || CFG_NO_ROOM;

`endif

endmodule
